circuit_sweep_ctrl: RTL and testbench

Synthesizable sequencer that drives the four inputs {w,x,y,z} of a 4-input combinational circuit (circuit1, structural or dataflow variant) through all 16 combinations. For each vector it waits a programmable settle time, samples output f, and builds the 16-bit truth table. It compares the table against a golden table and reports pass/fail, the mismatch count and the first failing vector. It replaces hand-written stimulus sequences and sits between the circuit under test and board-level status LEDs or a bench monitor.

---
 rtl/circuit_test_pkg.sv | 17 +
 rtl/settle_timer.sv | 26 ++
 rtl/circuit_sweep_ctrl.sv | 150 +++++++++++++++
 tb/tb_circuit_sweep_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/circuit_test_pkg.sv
// rtl/circuit_test_pkg.sv - shared types and constants for the circuit1 sweep controller
package circuit_test_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      FINISH
   } state_t;

   localparam int VEC_W = 4;
   localparam int N_VEC = 16;

   // Golden truth table of circuit1; bit n is f for {w,x,y,z} = n.
   localparam logic [N_VEC-1:0] CIRCUIT1_TT = 16'h6CA9;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - 4-bit settle down-counter with load and expire pulse
module settle_timer (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   input  logic       i_en,
   output logic       o_expire
);

   logic [3:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= 4'd0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Loaded with S-1, so expire is seen on the S-th enabled cycle.
   assign o_expire = i_en && (r_cnt == 4'd0);

endmodule

// File: rtl/circuit_sweep_ctrl.sv
// rtl/circuit_sweep_ctrl.sv - sweeps all 16 input vectors of circuit1, captures f and grades it
module circuit_sweep_ctrl
   import circuit_test_pkg::*;
#(
   parameter int unsigned      SETTLE_CYCLES = 2,
   parameter logic [N_VEC-1:0] EXPECTED_TT   = 16'h0000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic             i_f_in,
   output logic             o_w,
   output logic             o_x,
   output logic             o_y,
   output logic             o_z,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [N_VEC-1:0] o_truth_table,
   output logic [4:0]       o_mismatch_count,
   output logic [VEC_W-1:0] o_first_fail,
   output logic             o_fail_seen
);

   localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [VEC_W-1:0] r_vec;
   logic [N_VEC-1:0] r_tt;
   logic [4:0]       r_mis_cnt;
   logic [VEC_W-1:0] r_first_fail;
   logic             r_fail_seen;
   logic             r_pass;
   logic             r_done;
   logic             r_busy;

   logic             w_load;
   logic             w_timer_en;
   logic             w_expire;
   logic             w_clear;
   logic             w_sample;
   logic             w_last;
   logic             w_mis;

   assign w_last = &r_vec;
   assign w_mis  = (i_f_in != EXPECTED_TT[r_vec]);

   settle_timer u_settle_timer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_load),
      .i_load_val (LOAD_VAL),
      .i_en       (w_timer_en),
      .o_expire   (w_expire)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (i_start) w_next_state = SETTLE;
         SETTLE:  begin
            if (i_abort)       w_next_state = IDLE;
            else if (w_expire) w_next_state = SAMPLE;
         end
         SAMPLE:  begin
            if (i_abort)     w_next_state = IDLE;
            else if (w_last) w_next_state = FINISH;
            else             w_next_state = SETTLE;
         end
         FINISH:  w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Abort beats a coinciding sample: the sample strobe is suppressed.
   always_comb begin
      w_load     = 1'b0;
      w_timer_en = 1'b0;
      w_clear    = 1'b0;
      w_sample   = 1'b0;
      case (r_state)
         IDLE: begin
            w_clear = i_start;
            w_load  = i_start;
         end
         SETTLE: w_timer_en = 1'b1;
         SAMPLE: begin
            w_sample = !i_abort;
            w_load   = !i_abort && !w_last;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vec        <= '0;
         r_tt         <= '0;
         r_mis_cnt    <= '0;
         r_first_fail <= '0;
         r_fail_seen  <= 1'b0;
         r_pass       <= 1'b0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_busy <= (w_next_state != IDLE);
         r_done <= w_sample && w_last;
         if (w_clear) begin
            r_vec       <= '0;
            r_tt        <= '0;
            r_mis_cnt   <= '0;
            r_fail_seen <= 1'b0;
            r_pass      <= 1'b0;
         end
         if (w_sample) begin
            r_tt[r_vec] <= i_f_in;
            if (w_mis) begin
               r_mis_cnt <= r_mis_cnt + 5'd1;
               if (!r_fail_seen) begin
                  r_first_fail <= r_vec;
                  r_fail_seen  <= 1'b1;
               end
            end
            // Grade includes the final sample, so pass is valid alongside done.
            if (w_last) r_pass <= (r_mis_cnt == 5'd0) && !w_mis;
            else        r_vec  <= r_vec + VEC_W'(1);
         end
      end
   end

   assign {o_w, o_x, o_y, o_z} = r_vec;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_pass           = r_pass;
   assign o_truth_table    = r_tt;
   assign o_mismatch_count = r_mis_cnt;
   assign o_first_fail     = r_first_fail;
   assign o_fail_seen      = r_fail_seen;

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// tb/tb_circuit_sweep_ctrl.sv - scoreboard bench for circuit_sweep_ctrl
module tb_circuit_sweep_ctrl;
   import circuit_test_pkg::*;

   localparam int S      = 2;
   localparam int PERIOD = S + 1;
   localparam int SWEEP  = 16 * PERIOD;

   typedef struct {
      logic [15:0] tt;
      logic [4:0]  mis;
      logic [3:0]  ff;
      logic        fs;
      logic        ps;
      int          done_cyc;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        f_in;
   logic        o_w, o_x, o_y, o_z;
   logic        o_busy, o_done, o_pass, o_fail_seen;
   logic [15:0] o_truth_table;
   logic [4:0]  o_mismatch_count;
   logic [3:0]  o_first_fail;
   logic [15:0] model_tt = CIRCUIT1_TT;
   logic        prev_done = 1'b0;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   circuit_sweep_ctrl #(
      .SETTLE_CYCLES (S),
      .EXPECTED_TT   (CIRCUIT1_TT)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_start          (start),
      .i_abort          (abort),
      .i_f_in           (f_in),
      .o_w              (o_w),
      .o_x              (o_x),
      .o_y              (o_y),
      .o_z              (o_z),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_pass           (o_pass),
      .o_truth_table    (o_truth_table),
      .o_mismatch_count (o_mismatch_count),
      .o_first_fail     (o_first_fail),
      .o_fail_seen      (o_fail_seen)
   );

   // Combinational circuit under test: model_tt holds the (possibly faulty) behaviour.
   assign f_in = model_tt[{o_w, o_x, o_y, o_z}];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endfunction

   function automatic void push_exp(input int k, input logic [15:0] tt, input logic [4:0] mis,
                                    input logic [3:0] ff, input logic fs, input logic ps);
      exp_t e;
      e.tt = tt; e.mis = mis; e.ff = ff; e.fs = fs; e.ps = ps;
      e.done_cyc = k + SWEEP;
      q.push_back(e);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && o_done) begin
         chk("done_single_cycle", 32'(prev_done), 32'd0);
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
         end else begin
            e = q.pop_front();
            chk("done_cycle", cyc, e.done_cyc);
            chk("truth_table", 32'(o_truth_table), 32'(e.tt));
            chk("mismatch_count", 32'(o_mismatch_count), 32'(e.mis));
            chk("fail_seen", 32'(o_fail_seen), 32'(e.fs));
            chk("pass", 32'(o_pass), 32'(e.ps));
            chk("busy_at_done", 32'(o_busy), 32'd1);
            if (e.fs) chk("first_fail", 32'(o_first_fail), 32'(e.ff));
         end
      end
      prev_done <= o_done;
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic start_sweep(output int k);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = cyc;
   endtask

   task automatic finish_sweep(input int k);
      int n;
      n = 0;
      while (q.size() != 0 && n < SWEEP + 20) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("sweep_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
      wait_cyc(k + SWEEP + 1);
      chk("busy_falls", 32'(o_busy), 32'd0);
      chk("done_low_after", 32'(o_done), 32'd0);
   endtask

   initial begin
      int k;
      repeat (3) @(negedge clk);
      chk("reset_flags", 32'({o_w, o_x, o_y, o_z, o_busy, o_done, o_pass, o_fail_seen, o_first_fail}), 32'd0);
      chk("reset_tables", 32'({o_mismatch_count, o_truth_table}), 32'd0);
      rst_n = 1'b1;

      // Good circuit, with vector hold timing checked.
      model_tt = CIRCUIT1_TT;
      start_sweep(k);
      push_exp(k, 16'h6CA9, 5'd0, 4'd0, 1'b0, 1'b1);
      chk("busy_at_start", 32'(o_busy), 32'd1);
      for (int n = 0; n < 16; n++) begin
         wait_cyc(k + n * PERIOD);
         chk("vec_first_cycle", 32'({o_w, o_x, o_y, o_z}), n);
         wait_cyc(k + n * PERIOD + S);
         chk("vec_last_cycle", 32'({o_w, o_x, o_y, o_z}), n);
      end
      wait_cyc(k + SWEEP);
      chk("vec_held_in_finish", 32'({o_w, o_x, o_y, o_z}), 32'd15);
      finish_sweep(k);

      // f stuck at 0.
      model_tt = 16'h0000;
      start_sweep(k);
      push_exp(k, 16'h0000, 5'd8, 4'd0, 1'b1, 1'b0);
      finish_sweep(k);

      // Only vector 10 inverted.
      model_tt = CIRCUIT1_TT ^ 16'h0400;
      start_sweep(k);
      push_exp(k, 16'h68A9, 5'd1, 4'd10, 1'b1, 1'b0);
      finish_sweep(k);

      // Start mid-sweep and during FINISH are both ignored.
      model_tt = CIRCUIT1_TT;
      start_sweep(k);
      push_exp(k, 16'h6CA9, 5'd0, 4'd0, 1'b0, 1'b1);
      wait_cyc(k + 20);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(k + SWEEP);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_sweep(k);
      wait_cyc(k + SWEEP + 3);
      chk("no_restart_from_finish", 32'(o_busy), 32'd0);

      // Abort after vectors 0..7 were sampled.
      start_sweep(k);
      wait_cyc(k + 25);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 32'(o_busy), 32'd0);
      chk("abort_done", 32'(o_done), 32'd0);
      chk("abort_pass", 32'(o_pass), 32'd0);
      chk("abort_partial_tt", 32'(o_truth_table), 32'h00A9);
      chk("abort_partial_mis", 32'(o_mismatch_count), 32'd0);
      wait_cyc(k + SWEEP + 5);
      chk("abort_stays_idle", 32'(o_busy), 32'd0);
      start_sweep(k);
      push_exp(k, 16'h6CA9, 5'd0, 4'd0, 1'b0, 1'b1);
      finish_sweep(k);

      // Reset mid-sweep with mismatches already counted.
      model_tt = 16'h0000;
      start_sweep(k);
      wait_cyc(k + 30);
      chk("pre_reset_mis", 32'(o_mismatch_count), 32'd4);
      chk("pre_reset_fail_seen", 32'(o_fail_seen), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_flags", 32'({o_w, o_x, o_y, o_z, o_busy, o_done, o_pass, o_fail_seen, o_first_fail}), 32'd0);
      chk("async_reset_tables", 32'({o_mismatch_count, o_truth_table}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_tt = CIRCUIT1_TT;
      start_sweep(k);
      push_exp(k, 16'h6CA9, 5'd0, 4'd0, 1'b0, 1'b1);
      finish_sweep(k);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
